sumsq_stream: RTL and testbench

- Parametrised successor to the two-input sum-of-squares datapath used in word-length optimisation runs.
- Computes the sum of squares across N_CH unsigned fixed-point channels per sample.
- Can accumulate that sum over a frame of samples, giving an energy or squared-norm result.
- Quantises inputs and the result to a programmable fractional word length by zeroing LSBs. Uses valid/ready handshakes with backpressure.

---
 rtl/sumsq_pkg.sv | 33 +++
 rtl/sumsq_addtree.sv | 20 ++
 rtl/sumsq_stream.sv | 144 ++++++++++++++
 tb/tb_sumsq_stream.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sumsq_pkg.sv
// sumsq_pkg: shared helpers for the sum-of-squares stream.
// Quantisation mask, round/saturate and ceiling-log2 functions.
package sumsq_pkg;

  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Ones in bits [w-1:drop], zeros elsewhere.
  function automatic logic [63:0] qmask(input int w, input int drop);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++)
      m[i] = (i >= drop) && (i < w);
    return m;
  endfunction

  // Half-up rounding to the kept bits; carry out of w bits
  // saturates to the largest representable masked value.
  function automatic logic [63:0] round_sat(input logic [63:0] v,
                                            input int w,
                                            input int drop);
    logic [63:0] t;
    if (drop == 0) return v & qmask(w, 0);
    t = v + (64'd1 << (drop - 1));
    if (t >= (64'd1 << w)) return qmask(w, drop);
    return t & qmask(w, drop);
  endfunction

endpackage

// File: rtl/sumsq_addtree.sv
// sumsq_addtree: combinational unsigned sum of N packed W-bit terms.
// Ports: terms (N*W, term 0 in LSBs) -> sum (W+clog2(N)).
module sumsq_addtree
  import sumsq_pkg::*;
#(
  parameter int W = 28,
  parameter int N = 2,
  localparam int SW = W + clog2(N)
) (
  input  logic [N*W-1:0] terms,
  output logic [SW-1:0]  sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++)
      sum = sum + SW'(terms[i*W +: W]);
  end

endmodule

// File: rtl/sumsq_stream.sv
// sumsq_stream: 3-stage square / sum / frame-accumulate stream with valid/ready.
// Ports: clk, rstn, acc_len, in_* (valid/ready/data/last), out_* (valid/ready/data/count). Macro SUMSQ_STREAM_ROUND_EN selects rounding.
module sumsq_stream
  import sumsq_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int IWL_IN    = 2,
  parameter int FWL_IN    = 12,
  parameter int FWL_Q     = 12,
  parameter int FWL_C     = 24,
  parameter int ACC_LEN_W = 8,
  localparam int IN_W  = IWL_IN + FWL_IN,
  localparam int SQ_W  = 2 * IN_W,
  localparam int SUM_W = SQ_W + clog2(N_CH),
  localparam int OUT_W = SUM_W + ACC_LEN_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ACC_LEN_W-1:0] acc_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CH*IN_W-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic [ACC_LEN_W-1:0] out_count
);

  localparam int QDROP = FWL_IN - FWL_Q;
  localparam int CDROP = 2 * FWL_IN - FWL_C;
  localparam logic [IN_W-1:0] IMASK = IN_W'(qmask(IN_W, QDROP));

  logic [N_CH-1:0][SQ_W-1:0] sq_d;
  logic [N_CH-1:0][SQ_W-1:0] s1_sq;
  logic                      s1_valid;
  logic                      s1_last;
  logic [SUM_W-1:0]          sum_d;
  logic [SUM_W-1:0]          s2_sum;
  logic                      s2_valid;
  logic                      s2_last;
  logic [OUT_W-1:0]          acc;
  logic [ACC_LEN_W-1:0]      cnt;
  logic [ACC_LEN_W-1:0]      len;
  logic                      busy;

  logic                      s3_take;
  logic                      s2_ready;
  logic                      s1_ready;
  logic [OUT_W-1:0]          nacc;
  logic [ACC_LEN_W-1:0]      ncnt;
  logic [ACC_LEN_W-1:0]      nlen;
  logic                      close;
  logic [OUT_W-1:0]          qout;

  always_comb begin
    sq_d = '0;
    for (int c = 0; c < N_CH; c++)
      sq_d[c] = SQ_W'(in_data[c*IN_W +: IN_W] & IMASK)
              * SQ_W'(in_data[c*IN_W +: IN_W] & IMASK);
  end

  sumsq_addtree #(
    .W(SQ_W),
    .N(N_CH)
  ) u_tree (
    .terms(s1_sq),
    .sum  (sum_d)
  );

  // S3 absorbs only when the result register is free or leaving.
  assign s3_take  = s2_valid && (!out_valid || out_ready);
  assign s2_ready = !s2_valid || s3_take;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  // busy is low when idle or when the last frame just closed,
  // so the next sample always opens a fresh frame.
  always_comb begin
    if (!busy) begin
      nacc = OUT_W'(s2_sum);
      ncnt = ACC_LEN_W'(1);
      nlen = (acc_len == '0) ? ACC_LEN_W'(1) : acc_len;
    end else begin
      nacc = acc + OUT_W'(s2_sum);
      ncnt = cnt + ACC_LEN_W'(1);
      nlen = len;
    end
    close = (ncnt == nlen) || s2_last;
  end

`ifdef SUMSQ_STREAM_ROUND_EN
  assign qout = OUT_W'(round_sat(64'(nacc), OUT_W, CDROP));
`else
  assign qout = OUT_W'(64'(nacc) & qmask(OUT_W, CDROP));
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_sq     <= '0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_sum    <= '0;
      s2_last   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      len       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sq   <= sq_d;
          s1_last <= in_last;
        end
      end
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sum  <= sum_d;
          s2_last <= s1_last;
        end
      end
      if (s3_take) begin
        acc       <= nacc;
        cnt       <= ncnt;
        len       <= nlen;
        busy      <= !close;
        out_valid <= close;
        if (close) begin
          out_data  <= qout;
          out_count <= ncnt;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sumsq_stream.sv
// tb_sumsq_stream: directed table and sequence checks for sumsq_stream.
// Three instances: default, FWL_Q=10, FWL_C=22, sharing one input stream.
module tb_sumsq_stream;

  localparam int IN_W  = 14;
  localparam int OUT_W = 37;
  localparam int LW    = 8;
`ifdef SUMSQ_STREAM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [LW-1:0]     acc_len = 8'd1;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic [2*IN_W-1:0] in_data = '0;
  logic              out_ready = 1'b1;
  logic              in_ready, in_ready_b, in_ready_c;
  logic              out_valid_a, out_valid_b, out_valid_c;
  logic [OUT_W-1:0]  out_data_a, out_data_b, out_data_c;
  logic [LW-1:0]     out_count_a, out_count_b, out_count_c;

  always #5 clk = ~clk;

  sumsq_stream u_a (
    .clk(clk), .rstn(rstn), .acc_len(acc_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_count(out_count_a)
  );

  sumsq_stream #(.FWL_Q(10)) u_b (
    .clk(clk), .rstn(rstn), .acc_len(acc_len),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_count(out_count_b)
  );

  sumsq_stream #(.FWL_C(22)) u_c (
    .clk(clk), .rstn(rstn), .acc_len(acc_len),
    .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_c), .out_ready(out_ready),
    .out_data(out_data_c), .out_count(out_count_c)
  );

  int checks = 0;
  int failures = 0;

  logic [LW+OUT_W-1:0] qa[$];
  logic [LW+OUT_W-1:0] qb[$];
  logic [LW+OUT_W-1:0] qc[$];
  logic                hold = 1'b0;
  logic [OUT_W-1:0]    hold_d;
  logic [LW-1:0]       hold_n;

  // Inputs change at posedge+2, so negedge values are those seen
  // by the next posedge.
  always @(negedge clk) begin
    if (rstn && hold) begin
      checks++;
      if (!(out_valid_a && out_data_a == hold_d
            && out_count_a == hold_n)) begin
        failures++;
        $display("FAIL hold_stable actual=%0b/%0d/%0d required=1/%0d/%0d",
                 out_valid_a, out_data_a, out_count_a, hold_d, hold_n);
      end
    end
    hold   = rstn && out_valid_a && !out_ready;
    hold_d = out_data_a;
    hold_n = out_count_a;
    if (rstn && out_ready) begin
      if (out_valid_a) qa.push_back({out_count_a, out_data_a});
      if (out_valid_b) qb.push_back({out_count_b, out_data_b});
      if (out_valid_c) qc.push_back({out_count_c, out_data_c});
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [IN_W-1:0] c0, input logic [IN_W-1:0] c1,
                      input logic last);
    bit rdy;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = {c1, c0};
    in_last  = last;
    do begin
      @(negedge clk);
      rdy = in_ready && in_ready_b && in_ready_c;
      @(posedge clk);
      #2;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic [OUT_W-1:0] ea,
                            input logic [OUT_W-1:0] eb,
                            input logic [OUT_W-1:0] ec,
                            input logic [LW-1:0] en);
    int n;
    logic [LW+OUT_W-1:0] r;
    n = 0;
    while ((qa.size() == 0 || qb.size() == 0 || qc.size() == 0) && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (qa.size() == 0 || qb.size() == 0 || qc.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_result required=result", name);
    end else begin
      r = qa.pop_front();
      chk({name, "_a"}, 64'(r[OUT_W-1:0]), 64'(ea));
      chk({name, "_cnt"}, 64'(r[LW+OUT_W-1:OUT_W]), 64'(en));
      r = qb.pop_front();
      chk({name, "_b"}, 64'(r[OUT_W-1:0]), 64'(eb));
      r = qc.pop_front();
      chk({name, "_c"}, 64'(r[OUT_W-1:0]), 64'(ec));
      chk({name, "_c_cnt"}, 64'(r[LW+OUT_W-1:OUT_W]), 64'(en));
    end
  endtask

  typedef struct {
    logic [IN_W-1:0]  c0;
    logic [IN_W-1:0]  c1;
    logic [LW-1:0]    len;
    logic             last;
    logic [OUT_W-1:0] ea;
    logic [OUT_W-1:0] eb;
    logic [OUT_W-1:0] ec;
    logic [LW-1:0]    en;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit     saw_stall;
    time    t0;
    logic [OUT_W-1:0] e;

    tbl[0] = '{14'h1000, 14'h1000, 8'd1, 1'b0,
               37'd33554432, 37'd33554432, 37'd33554432, 8'd1};
    tbl[1] = '{14'h1003, 14'h0000, 8'd1, 1'b0,
               37'd16801801, 37'd16777216, 37'd16801800, 8'd1};
    tbl[2] = '{14'h0001, 14'h0000, 8'd0, 1'b0,
               37'd1, 37'd0, 37'd0, 8'd1};
    tbl[3] = '{14'h0002, 14'h0000, 8'd5, 1'b1,
               37'd4, 37'd0, 37'd4, 8'd1};
    tbl[4] = '{14'h0001, 14'h0001, 8'd1, 1'b0,
               37'd2, 37'd0, RND ? 37'd4 : 37'd0, 8'd1};
    tbl[5] = '{14'h3fff, 14'h3fff, 8'd1, 1'b0,
               37'd536805378, 37'd536608800,
               RND ? 37'd536805380 : 37'd536805376, 8'd1};
    tbl[6] = '{14'h0003, 14'h0002, 8'd1, 1'b0,
               37'd13, 37'd0, 37'd12, 8'd1};
    tbl[7] = '{14'h2000, 14'h0800, 8'd1, 1'b1,
               37'd71303168, 37'd71303168, 37'd71303168, 8'd1};

    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_out_data", 64'(out_data_a), 64'd0);
    chk("rst_out_count", 64'(out_count_a), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rstn = 1'b1;
    @(posedge clk);
    #2;

    // Latency: three registered stages from the accepting edge.
    acc_len = 8'd1;
    in_valid = 1'b1;
    in_data = {14'h1000, 14'h1000};
    in_last = 1'b0;
    @(negedge clk);
    chk("lat_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #2;
    idle();
    @(negedge clk);
    chk("lat_edge1", 64'(out_valid_a), 64'd0);
    @(negedge clk);
    chk("lat_edge2", 64'(out_valid_a), 64'd0);
    @(negedge clk);
    chk("lat_edge3", 64'(out_valid_a), 64'd1);
    expect_res("lat", 37'd33554432, 37'd33554432, 37'd33554432, 8'd1);
    @(posedge clk);
    #2;

    for (int i = 0; i < 8; i++) begin
      acc_len = tbl[i].len;
      send(tbl[i].c0, tbl[i].c1, tbl[i].last);
      idle();
      expect_res($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb,
                 tbl[i].ec, tbl[i].en);
    end

    // Two back-to-back 4-sample frames.
    acc_len = 8'd4;
    t0 = $time;
    for (int i = 0; i < 8; i++) send(14'h1000, 14'h1000, 1'b0);
    chk("no_bubble_cycles", 64'(($time - t0) / 10), 64'd8);
    idle();
    expect_res("frame4_a", 37'd134217728, 37'd134217728, 37'd134217728, 8'd4);
    expect_res("frame4_b", 37'd134217728, 37'd134217728, 37'd134217728, 8'd4);

    // Early close on last, then a full 8-sample frame.
    acc_len = 8'd8;
    send(14'h1000, 14'h1000, 1'b0);
    send(14'h1000, 14'h1000, 1'b0);
    send(14'h1000, 14'h1000, 1'b1);
    for (int i = 0; i < 8; i++) send(14'h1000, 14'h1000, 1'b0);
    idle();
    expect_res("last3", 37'd100663296, 37'd100663296, 37'd100663296, 8'd3);
    expect_res("full8", 37'd268435456, 37'd268435456, 37'd268435456, 8'd8);

    // Backpressure during a continuous stream.
    acc_len = 8'd1;
    out_ready = 1'b0;
    saw_stall = 1'b0;
    fork
      begin
        for (int k = 0; k < 12; k++)
          send(14'(16 * (k + 1)), 14'h0000, 1'b0);
        idle();
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (!in_ready) saw_stall = 1'b1;
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    chk("bp_in_ready_dropped", 64'(saw_stall), 64'd1);
    for (int k = 0; k < 12; k++) begin
      e = 37'(256 * (k + 1) * (k + 1));
      expect_res($sformatf("bp%0d", k), e, e, e, 8'd1);
    end
    repeat (6) @(posedge clk);
    #2;
    chk("bp_no_dup", 64'(qa.size()), 64'd0);

    // Reset in the middle of a frame.
    acc_len = 8'd8;
    send(14'h1000, 14'h1000, 1'b0);
    send(14'h1000, 14'h1000, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("mid_rst_out_data", 64'(out_data_a), 64'd0);
    chk("mid_rst_out_count", 64'(out_count_a), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #2;
    acc_len = 8'd1;
    send(14'h0002, 14'h0000, 1'b0);
    idle();
    expect_res("post_rst", 37'd4, 37'd0, 37'd4, 8'd1);
    repeat (10) @(posedge clk);
    #2;
    chk("post_rst_no_extra", 64'(qa.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
